// File: rtl/uart_pkg.sv
// Shared state encoding, line levels and width helper for the arbitrated UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < value) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] pos;

    // Scan from farthest to nearest so the slot at ptr overrides everything else.
    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = '0;
        if (enable) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                pos = IDX_W'((int'(ptr) + i) % NUM_REQ);
                if (req[pos]) begin
                    grant      = '0;
                    grant[pos] = 1'b1;
                    idx        = pos;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbitrated UART transmitter sharing one tx line among NUM_REQ producers.
// Define UART_TX_ARB_PARITY_EN to append an even parity bit after the data bits.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned  NUM_REQ   = 4,
    parameter int unsigned  DATA_W    = 8,
    parameter int unsigned  STOP_BITS = 1,
    localparam int unsigned IDX_W     = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      baud_tick,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id
);

    localparam int unsigned CNT_W = clog2(DATA_W + 1);

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  shift_q;
    logic [NUM_REQ-1:0] win_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               accept;
`ifdef UART_TX_ARB_PARITY_EN
    logic               parity_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (state_q == StIdle && !rst),
        .grant  (win_grant),
        .idx    (win_idx)
    );

    assign req_ready = win_grant;
    assign accept    = |(req_valid & win_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            tx       <= TX_IDLE_LEVEL;
            busy     <= 1'b0;
            grant_id <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_ARB_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                // baud_tick is deliberately ignored here, so ALIGN always waits a fresh tick.
                StIdle: begin
                    if (accept) begin
                        shift_q  <= req_data[win_idx*DATA_W +: DATA_W];
                        grant_id <= win_idx;
                        ptr_q    <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                        busy     <= 1'b1;
                        state_q  <= StAlign;
`ifdef UART_TX_ARB_PARITY_EN
                        parity_q <= ^req_data[win_idx*DATA_W +: DATA_W];
`endif
                    end
                end
                StAlign: begin
                    if (baud_tick) begin
                        tx      <= START_LEVEL;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_tick) begin
                        tx      <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= '0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (baud_tick) begin
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_q   <= '0;
`ifdef UART_TX_ARB_PARITY_EN
                            tx      <= parity_q;
                            state_q <= StParity;
`else
                            tx      <= TX_IDLE_LEVEL;
                            state_q <= StStop;
`endif
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            tx      <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                StParity: begin
                    if (baud_tick) begin
                        tx      <= TX_IDLE_LEVEL;
                        state_q <= StStop;
                    end
                end
`endif
                // cnt_q is reused to count stop-bit periods.
                StStop: begin
                    if (baud_tick) begin
                        if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
                            cnt_q   <= '0;
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, hand sequences and a random
// run, all compared against a frame-level model built from per-tick bit queues.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int S  = 1;
    localparam int IW = $clog2(N);
`ifdef UART_TX_ARB_PARITY_EN
    localparam int P  = 1;
`else
    localparam int P  = 0;
`endif
    // Ticks from acceptance up to and including the one that returns to idle.
    localparam int FRAME_TICKS = 2 + W + P + S;

    logic          clk = 1'b0;
    logic          rst;
    logic          baud_tick;
    logic [N-1:0]  req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          tx;
    logic          busy;
    logic [IW-1:0] grant_id;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (W),
        .STOP_BITS (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Model: remaining tx levels of the current frame, one per future tick.
    bit            m_bits[$];
    logic          m_tx;
    logic [IW-1:0] m_gid;
    int            m_ptr;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  acc_evt;
    int  acc_idx;
    bit  did_tick;
    int  phase = 0;
    int  tick_count = 0;
    bit  cap[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_edge(input bit tk);
        int w;
        logic [W-1:0] d;
        acc_evt = 1'b0;
        if (rst) begin
            m_bits.delete();
            m_tx  = 1'b1;
            m_gid = '0;
            m_ptr = 0;
        end else if (m_bits.size() == 0) begin
            w = winner(req_valid, m_ptr);
            if (w >= 0) begin
                d = req_data[w*W +: W];
                m_bits.push_back(1'b0);
                for (int i = 0; i < W; i++) m_bits.push_back(d[i]);
                if (P != 0) m_bits.push_back(^d);
                for (int i = 0; i <= S; i++) m_bits.push_back(1'b1);
                m_gid   = IW'(w);
                m_ptr   = (w + 1) % N;
                acc_evt = 1'b1;
                acc_idx = w;
            end
        end else if (tk) begin
            m_tx = m_bits.pop_front();
        end
    endtask

    // One clock: t<0 uses a tick every 4th cycle, otherwise t drives baud_tick.
    task automatic step(input int t);
        bit tk;
        int w;
        logic [N-1:0] one;
        logic [N-1:0] exp_rdy;
        one = 1;
        tk = (t < 0) ? (phase % 4 == 3) : (t != 0);
        phase++;
        baud_tick = tk;
        #1;
        w = winner(req_valid, m_ptr);
        exp_rdy = (!rst && m_bits.size() == 0 && w >= 0) ? (one << w) : '0;
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        model_edge(tk);
        did_tick = tk;
        if (tk) tick_count++;
        #1;
        chk("tx", tx, m_tx);
        chk("busy", busy, m_bits.size() != 0);
        chk("grant_id", grant_id, m_gid);
        @(negedge clk);
    endtask

    task automatic wait_accept(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            step(-1);
            if (acc_evt) begin
                ok = 1'b1;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int max);
        for (int c = 0; c < max; c++) begin
            if (!busy && m_bits.size() == 0) return;
            step(-1);
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(-1);
        step(-1);
        rst = 1'b0;
    endtask

    task automatic frame_capture(input int r, input logic [W-1:0] d);
        bit ok;
        req_data[r*W +: W] = d;
        req_valid    = '0;
        req_valid[r] = 1'b1;
        wait_accept(20, ok);
        req_valid = '0;
        cap.delete();
        if (!ok) return;
        for (int c = 0; c < 600; c++) begin
            step(-1);
            if (did_tick) cap.push_back(tx);
            if (!busy) return;
        end
        chk("frame_timeout", 0, 1);
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [W-1:0] data;
        int           gid;
    } vec_t;

    initial begin
        vec_t tbl[9];
        bit   exp_q[$];
        int   order[6];
        int   at[6];
        int   exp_order[6];
        int   n;
        bit   ok;
        bit   tk;
        bit   last_tk;
        logic [N-1:0] one;
        one = 1;

        // Expected grants follow the pointer from reset (0) through each entry.
        tbl[0] = '{4'b0100, 8'hA5, 2};
        tbl[1] = '{4'b1011, 8'h00, 3};
        tbl[2] = '{4'b1011, 8'hFF, 0};
        tbl[3] = '{4'b1011, 8'h80, 1};
        tbl[4] = '{4'b1011, 8'h01, 3};
        tbl[5] = '{4'b0110, 8'h3C, 1};
        tbl[6] = '{4'b0110, 8'hC3, 2};
        tbl[7] = '{4'b0001, 8'h55, 0};
        tbl[8] = '{4'b1000, 8'hAA, 3};
        exp_order = '{0, 1, 3, 0, 1, 3};

        m_tx = 1'b1; m_gid = '0; m_ptr = 0;
        rst = 1'b1; baud_tick = 1'b0; req_data = '0;
        req_valid = 4'b0101;
        @(negedge clk);
        step(-1);
        step(-1);
        chk("init_ready", req_ready, 0);
        chk("init_tx", tx, 1);
        chk("init_busy", busy, 0);
        chk("init_gid", grant_id, 0);
        rst = 1'b0;
        req_valid = '0;

        // Single frame 0xA5 from requester 2.
        exp_q = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
        if (P != 0) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        frame_capture(2, 8'hA5);
        chk("a5_gid", grant_id, 2);
        chk("a5_len", cap.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            chk("a5_bit", (k < cap.size()) ? cap[k] : 1'bx, exp_q[k]);

        // Reset while idle.
        for (int c = 0; c < 6; c++) step(-1);
        rst = 1'b1;
        req_valid = 4'b0110;
        #1;
        chk("rst_idle_ready", req_ready, 0);
        step(-1);
        chk("rst_idle_tx", tx, 1);
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_gid", grant_id, 0);
        rst = 1'b0;
        req_valid = '0;

        // Round robin with 1011 held: order and back-to-back spacing.
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1011;
        for (int g = 0; g < 6; g++) begin
            wait_accept(200, ok);
            order[g] = acc_idx;
            at[g]    = tick_count;
        end
        req_valid = '0;
        for (int g = 0; g < 6; g++) begin
            chk("rr_order", order[g], exp_order[g]);
            if (g > 0) chk("rr_gap", at[g] - at[g-1], FRAME_TICKS);
        end
        wait_idle(200);

        // Table of grants.
        do_reset();
        for (int t = 0; t < 9; t++) begin
            wait_idle(200);
            req_valid = tbl[t].valid;
            for (int i = 0; i < N; i++) req_data[i*W +: W] = tbl[t].data;
            #1;
            chk("tbl_ready", req_ready, one << tbl[t].gid);
            wait_accept(20, ok);
            chk("tbl_gid", grant_id, tbl[t].gid);
            req_valid = '0;
        end
        wait_idle(200);

        // Tick coincident with acceptance is ignored; start bit lasts a full period.
        do_reset();
        req_data[1*W +: W] = 8'h3D;
        req_valid = 4'b0010;
        step(1);
        req_valid = '0;
        chk("coinc_busy", busy, 1);
        chk("coinc_hold", tx, 1);
        for (int c = 0; c < 3; c++) begin
            step(0);
            chk("coinc_hold", tx, 1);
        end
        step(1);
        chk("coinc_start", tx, 0);
        for (int c = 0; c < 3; c++) begin
            step(0);
            chk("coinc_start_len", tx, 0);
        end
        step(1);
        chk("coinc_d0", tx, 1);
        wait_idle(200);

        // Reset during data bit 3 with requests pending; pointer must restart at 0.
        do_reset();
        req_data[0*W +: W] = 8'h5A;
        req_data[3*W +: W] = 8'hC3;
        req_valid = 4'b1001;
        wait_accept(20, ok);
        chk("mid_first", grant_id, 0);
        n = 0;
        for (int c = 0; c < 100 && n < 5; c++) begin
            step(-1);
            if (did_tick) n++;
        end
        chk("mid_ticks", n, 5);
        chk("mid_d3", tx, 1);
        rst = 1'b1;
        step(-1);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gid", grant_id, 0);
        rst = 1'b0;
        step(-1);
        chk("mid_regrant_busy", busy, 1);
        chk("mid_regrant_gid", grant_id, 0);
        req_valid = '0;
        wait_idle(200);

`ifdef UART_TX_ARB_PARITY_EN
        frame_capture(0, 8'h07);
        chk("par07_len", cap.size(), FRAME_TICKS);
        chk("par07_bit", (cap.size() > 9) ? cap[9] : 1'bx, 1);
        frame_capture(0, 8'h03);
        chk("par03_bit", (cap.size() > 9) ? cap[9] : 1'bx, 0);
`endif

        // Random requesters, random tick spacing, occasional reset.
        last_tk = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[i*W +: W] = W'($urandom);
                    end
                end else if ($urandom_range(0, 63) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            tk = !last_tk && ($urandom_range(0, 2) == 0);
            last_tk = tk;
            step(tk ? 1 : 0);
            if (acc_evt) req_valid[acc_idx] = 1'b0;
        end
        rst = 1'b0;
        req_valid = '0;
        wait_idle(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit line among NUM_REQ byte producers. A round-robin arbiter accepts one byte at a time through a valid/ready handshake. An internal frame FSM serialises that byte (start, data LSB-first, stop) and advances one bit per cycle of the external baud_tick strobe produced by the baud tick generator. Sits between on-chip message sources and the UART pin.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data bits per frame (5..9)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
baud_tick  input  1  one-clk-wide strobe, one per bit period
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot accept; combinational
tx  output  1  serial line, idle high; registered
busy  output  1  frame in progress (state != IDLE); registered
grant_id  output  clog2(NUM_REQ)  index of last accepted requester; registered

Behaviour:
- Reset: tx=1, busy=0, grant_id=0, rr pointer=0, state=IDLE, bit counter=0, shift reg=0. req_ready=0 during reset. Reset mid-frame aborts the frame; tx returns to 1 on the next edge.
- States: IDLE -> ALIGN -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE: req_ready[g]=1 only for winner g. Winner = first asserted req_valid scanning from pointer upward, with wrap. Transfer occurs on an edge with valid&ready. That edge latches req_data[g] into the shift reg, sets grant_id=g, sets pointer=(g+1) mod NUM_REQ, busy=1, and moves to ALIGN.
- A baud_tick coincident with acceptance is ignored.
- Outside IDLE, req_ready=0 for all requesters.
- Requester rules: hold valid and data stable until ready. Dropping valid before a grant is legal and causes no transfer.
- ALIGN: on next baud_tick, tx=0 -> START. This aligns the start bit to a full bit period.
- START: on baud_tick, tx=shift[0], shift right, cnt=0 -> DATA.
- DATA: on baud_tick, if cnt==DATA_W-1 go to PARITY (if enabled) else STOP with tx=1. Otherwise cnt++, tx=next bit.
- STOP: tx=1. After STOP_BITS ticks in STOP, go to IDLE and set busy=0. The next acceptance may occur in that same IDLE cycle.
- Frame length: exactly 1+DATA_W+(parity)+STOP_BITS tick periods from the first tick after acceptance to return to IDLE.
- All requesters idle: stays in IDLE with tx=1, pointer unchanged.
- Single persistent requester: granted back-to-back with no extra idle bit.
- No tick change occurs between ticks: tx holds its value.
- Counter width: clog2(DATA_W+1). Pointer wraps modulo NUM_REQ.

Optional Feature:
UART_TX_ARB_PARITY_EN
- Defined: PARITY state inserted after DATA. tx=^data (even parity) for one tick period; frame grows by one bit. Parity is computed at acceptance and stored in a register.
- Undefined: no PARITY state or register; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg: state enum (IDLE, ALIGN, START, DATA, PARITY, STOP), TX_IDLE_LEVEL=1'b1, START_LEVEL=1'b0, clog2 helper.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer, enable; outputs one-hot grant and index. Purely combinational priority-from-pointer.
- Frame FSM and shift logic stay in the top module.

Test Plan:
- Reset: baud_tick every 4 clks, no valid; assert rst mid-idle -> tx=1, busy=0, req_ready=0, grant_id=0.
- Single frame: req_valid[2]=1, data 0xA5 -> ready[2] same cycle, grant_id=2. tx sequence per tick: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop). busy drops after the 10th tick.
- Round robin: req_valid=4'b1011 held continuously -> grants in order 0,1,3,0,1,3. Frames are back-to-back with no idle bit between stop and next ALIGN+start.
- Tick coincident with acceptance: force baud_tick high on the accept edge -> start bit begins on the following tick, not that one. Start bit lasts a full period.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 next edge, state IDLE, pointer=0. A pending request is re-granted cleanly after reset.
- Parity (UART_TX_ARB_PARITY_EN): data 0x07 -> parity bit 1, frame of 11 ticks. Data 0x03 -> parity bit 0.
